perf_counter_bank: RTL and testbench

- Parametrised Avalon-MM performance-counter bank: NUM_SECTIONS independent sections, each with a cycle (time) counter, an event counter and a sticky status word.
- Successor to the fixed 8-section / 64-bit perf counter, adding:
  - width and section-count generics
  - hardware event inputs
  - saturating event counts with sticky overflow flags
  - an optional coherent high-word snapshot
- Sits on the system interconnect as a control slave; firmware brackets code regions with start/stop writes.

---
 rtl/perf_counter_bank.sv | 149 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: Avalon-MM bank of NUM_SECTIONS time/event counters with sticky status.
// Define PERF_CNT_SNAPSHOT_EN to latch the high time word into a shadow on each low-word read.

module perf_counter_bank #(
  parameter  int NUM_SECTIONS = 8,
  parameter  int CNT_W        = 64,
  parameter  int EVT_W        = 32,
  localparam int ADDR_W       = $clog2(NUM_SECTIONS) + 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    begintransfer,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic [NUM_SECTIONS-1:0] evt_in,
  output logic [31:0]             readdata
);
  logic                               wr_stb, rd_stb, glb_rst, glb_en;
  logic [ADDR_W-1:0]                  sec;
  logic [1:0]                         reg_sel;
  logic [NUM_SECTIONS-1:0]            go, stop, snap, clr_tov, clr_esat;
  logic [NUM_SECTIONS-1:0][3:0][31:0] sec_regs;
  logic [31:0]                        rd_mux;
  logic                               unused_wd;

  assign wr_stb    = write & begintransfer;
  assign rd_stb    = read & begintransfer;
  assign sec       = address >> 2;
  assign reg_sel   = address[1:0];
  assign unused_wd = ^writedata[31:3];

  // Section 0 gates the whole bank; its own go counts as enabling.
  assign glb_rst = stop[0] & writedata[0];
  assign glb_en  = sec_regs[0][3][0] | go[0];

  for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_sec
    logic hit;
    assign hit         = (int'(sec) == s);
    assign stop[s]     = wr_stb & hit & (reg_sel == 2'd0);
    assign go[s]       = wr_stb & hit & (reg_sel == 2'd1);
    assign snap[s]     = rd_stb & hit & (reg_sel == 2'd0);
    assign clr_tov[s]  = wr_stb & hit & (reg_sel == 2'd3) & writedata[1];
    assign clr_esat[s] = wr_stb & hit & (reg_sel == 2'd3) & writedata[2];

    perf_section #(.CNT_W(CNT_W), .EVT_W(EVT_W)) u_sec (
      .clk      (clk),
      .reset_n  (reset_n),
      .glb_rst  (glb_rst),
      .glb_en   (glb_en),
      .go       (go[s]),
      .stop     (stop[s]),
      .snap     (snap[s]),
      .clr_tov  (clr_tov[s]),
      .clr_esat (clr_esat[s]),
      .evt      (evt_in[s]),
      .regs     (sec_regs[s])
    );
  end

  // Unpopulated sections fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int s = 0; s < NUM_SECTIONS; s++)
      if (int'(sec) == s) rd_mux = sec_regs[s][reg_sel];
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
endmodule

module perf_section #(
  parameter int CNT_W = 64,
  parameter int EVT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             glb_rst,
  input  logic             glb_en,
  input  logic             go,
  input  logic             stop,
  input  logic             snap,
  input  logic             clr_tov,
  input  logic             clr_esat,
  input  logic             evt,
  output logic [3:0][31:0] regs
);
  logic [CNT_W-1:0] tcnt;
  logic [EVT_W-1:0] ecnt;
  logic             run, tov, esat;
  logic             t_inc;
  logic [1:0]       e_inc;
  logic [EVT_W:0]   e_sum;
  logic [31:0]      hi_live, hi_rd;

  // The stop edge itself is not counted.
  assign t_inc = run & glb_en & ~stop;
  assign e_inc = glb_en ? ({1'b0, go} + {1'b0, evt & run}) : 2'd0;
  assign e_sum = {1'b0, ecnt} + (EVT_W+1)'(e_inc);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tcnt <= '0;
      ecnt <= '0;
      run  <= 1'b0;
      tov  <= 1'b0;
      esat <= 1'b0;
    end else if (glb_rst) begin
      tcnt <= '0;
      ecnt <= '0;
      run  <= 1'b0;
      tov  <= 1'b0;
      esat <= 1'b0;
    end else begin
      if (stop)    run <= 1'b0;
      else if (go) run <= 1'b1;
      if (t_inc) tcnt <= tcnt + CNT_W'(1);
      ecnt <= e_sum[EVT_W] ? '1 : e_sum[EVT_W-1:0];
      // Sticky flags: a same-cycle set beats a firmware clear.
      tov  <= (t_inc & (&tcnt)) | (tov & ~clr_tov);
      esat <= e_sum[EVT_W] | (esat & ~clr_esat);
    end

  if (CNT_W > 32) begin : g_hi
    assign hi_live = 32'(tcnt[CNT_W-1:32]);
  end else begin : g_no_hi
    assign hi_live = '0;
  end

`ifdef PERF_CNT_SNAPSHOT_EN
  logic [31:0] shadow_hi;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)     shadow_hi <= '0;
    else if (glb_rst) shadow_hi <= '0;
    else if (snap)    shadow_hi <= hi_live;
  assign hi_rd = shadow_hi;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign hi_rd       = hi_live;
`endif

  assign regs[0] = tcnt[31:0];
  assign regs[1] = hi_rd;
  assign regs[2] = 32'(ecnt);
  assign regs[3] = {29'b0, esat, tov, run};
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: directed table, corner-case sequences, then random traffic vs a model.
// Built with NUM_SECTIONS=6 (two unpopulated section slots), CNT_W=33, EVT_W=8.

module tb_perf_counter_bank;
  localparam int NS   = 6;
  localparam int CW   = 33;
  localparam int EW   = 8;
  localparam int AW   = 5;
  localparam int EMAX = (1 << EW) - 1;
  localparam longint TMOD = 64'd1 << CW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic          begintransfer, read, write;
  logic [31:0]   writedata;
  logic [NS-1:0] evt_in;
  logic [31:0]   readdata;

  int checks = 0;
  int errors = 0;

  perf_counter_bank #(.NUM_SECTIONS(NS), .CNT_W(CW), .EVT_W(EW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .begintransfer (begintransfer),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .evt_in        (evt_in),
    .readdata      (readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    bit          r;
    logic [4:0]  a;
    logic [31:0] d;
    int          idle;
    bit          chk;
    logic [31:0] want;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  // Reference model: per-section counters updated by the rules, one call per clock.
  longint m_time[NS];
  longint m_shadow[NS];
  int     m_evt[NS];
  bit     m_run[NS], m_tov[NS], m_esat[NS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus(input bit w, input bit r, input logic [4:0] a, input logic [31:0] d);
    write = w; read = r; begintransfer = 1'b1; address = a; writedata = d;
    cyc();
    write = 1'b0; read = 1'b0; begintransfer = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] want);
    bus(1'b0, 1'b1, a, 32'd0);
    chk(nm, readdata, want);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_time[i] = 0; m_shadow[i] = 0; m_evt[i] = 0;
      m_run[i] = 0; m_tov[i] = 0; m_esat[i] = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input int a);
    int s, r;
    s = a / 4; r = a % 4;
    if (s >= NS) return 32'd0;
    case (r)
      0: return 32'(m_time[s]);
`ifdef PERF_CNT_SNAPSHOT_EN
      1: return 32'(m_shadow[s]);
`else
      1: return 32'(m_time[s] >> 32);
`endif
      2: return 32'(m_evt[s]);
      default: return {29'b0, m_esat[s], m_tov[s], m_run[s]};
    endcase
  endfunction

  task automatic model_step();
    bit wr, rdq, ge, go, stop;
    int s, r, n;
    wr = write && begintransfer; rdq = read && begintransfer;
    s = int'(address) / 4; r = int'(address) % 4;
    if (wr && address == 0 && writedata[0]) begin
      model_clear();
      return;
    end
    ge = m_run[0] || (wr && address == 1);
    for (int i = 0; i < NS; i++) begin
      go   = wr && s == i && r == 1;
      stop = wr && s == i && r == 0;
      if (rdq && s == i && r == 0) m_shadow[i] = m_time[i] >> 32;
      if (wr && s == i && r == 3 && writedata[1]) m_tov[i] = 0;
      if (wr && s == i && r == 3 && writedata[2]) m_esat[i] = 0;
      if (m_run[i] && ge && !stop) begin
        m_time[i] = m_time[i] + 1;
        if (m_time[i] == TMOD) begin m_time[i] = 0; m_tov[i] = 1; end
      end
      n = m_evt[i] + (ge ? (int'(go) + int'(evt_in[i] && m_run[i])) : 0);
      if (n > EMAX) begin n = EMAX; m_esat[i] = 1; end
      m_evt[i] = n;
      if (stop) m_run[i] = 0;
      else if (go) m_run[i] = 1;
    end
  endtask

  initial begin
    logic [31:0] want;
    reset_n = 1'b0; address = '0; begintransfer = 0; read = 0; write = 0;
    writedata = '0; evt_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_rd", readdata, 32'd0);
    reset_n = 1'b1;
    cyc();

    // Basic start/stop bracketing, read map and decode.
    tbl.push_back('{1, 0, 1,  0,     10, 0, 0,  "go0"});
    tbl.push_back('{1, 0, 0,  0,     0,  0, 0,  "stop0"});
    tbl.push_back('{0, 1, 0,  0,     0,  1, 10, "t0_lo"});
    tbl.push_back('{0, 1, 2,  0,     0,  1, 1,  "e0_go"});
    tbl.push_back('{0, 1, 3,  0,     0,  1, 0,  "st0_stopped"});
    tbl.push_back('{0, 1, 1,  0,     0,  1, 0,  "t0_hi"});
    tbl.push_back('{0, 1, 4,  0,     0,  1, 0,  "t1_idle"});
    tbl.push_back('{1, 0, 2,  'hff,  0,  0, 0,  "wr_r2"});
    tbl.push_back('{0, 1, 2,  0,     0,  1, 1,  "e0_ro"});
    tbl.push_back('{1, 0, 25, 1,     0,  0, 0,  "wr_oor"});
    tbl.push_back('{0, 1, 25, 0,     0,  1, 0,  "rd_oor"});
    tbl.push_back('{1, 0, 0,  1,     0,  0, 0,  "grst"});
    tbl.push_back('{0, 1, 0,  0,     0,  1, 0,  "t0_grst"});
    tbl.push_back('{0, 1, 2,  0,     0,  1, 0,  "e0_grst"});
    foreach (tbl[i]) begin
      bus(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      if (tbl[i].chk) chk(tbl[i].nm, readdata, tbl[i].want);
      repeat (tbl[i].idle) cyc();
    end

    // Section 2 running with section 0 stopped: nothing counts.
    bus(1, 0, 9, 0);
    rd("t2_gated0", 8, 0);
    rd("e2_gated0", 10, 0);
    for (int i = 0; i < 5; i++) begin evt_in[2] = 1; cyc(); evt_in[2] = 0; cyc(); end
    rd("t2_frozen", 8, 0);
    rd("e2_frozen", 10, 0);
    bus(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin evt_in[2] = 1; cyc(); evt_in[2] = 0; cyc(); end
    rd("e2_counted", 10, 5);
    rd("e0_go0", 2, 1);

    // Event saturation on section 1; status clear loses to a same-cycle set.
    bus(1, 0, 5, 0);
    evt_in[1] = 1;
    repeat (300) cyc();
    bus(1, 0, 7, 4);
    evt_in[1] = 0;
    rd("e1_sat", 6, 255);
    rd("st1_set_wins", 7, 5);
    bus(1, 0, 7, 4);
    rd("st1_esat_clr", 7, 1);
    rd("e1_sat_hold", 6, 255);

    // Time counter wrap at 2^33-1 on section 0.
    force dut.g_sec[0].u_sec.tcnt = 33'h1_FFFF_FFFF;
    #1 release dut.g_sec[0].u_sec.tcnt;
    cyc();
    bus(1, 0, 0, 0);
    rd("t0_wrap_lo", 0, 0);
    rd("t0_wrap_hi", 1, 0);
    rd("st0_tov", 3, 2);
    bus(1, 0, 3, 2);
    rd("st0_tov_clr", 3, 0);

    // Low/high read across a carry out of the low word.
    bus(1, 0, 1, 0);
    force dut.g_sec[0].u_sec.tcnt = 33'h0_FFFF_FFFF;
    #1 release dut.g_sec[0].u_sec.tcnt;
    rd("carry_lo", 0, 32'hFFFF_FFFF);
`ifdef PERF_CNT_SNAPSHOT_EN
    rd("carry_hi_snap", 1, 0);
`else
    rd("carry_hi_live", 1, 1);
`endif

    // Global reset while every section runs.
    for (int s = 1; s < NS; s++) bus(1, 0, 5'(s * 4 + 1), 0);
    evt_in = '1;
    repeat (5) cyc();
    evt_in = '0;
    bus(1, 0, 0, 1);
    for (int s = 0; s < NS; s++) begin
      rd($sformatf("grst_t%0d", s), 5'(s * 4), 0);
      rd($sformatf("grst_e%0d", s), 5'(s * 4 + 2), 0);
      rd($sformatf("grst_st%0d", s), 5'(s * 4 + 3), 0);
    end

    // Asynchronous reset mid-count clears readdata without a clock edge.
    bus(1, 0, 1, 0);
    repeat (5) cyc();
    rd("t0_restart", 0, 5);
    repeat (2) cyc();
    #2 reset_n = 1'b0;
    #1 chk("async_rst_rd", readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd("t0_after_rst", 0, 0);
    rd("st0_after_rst", 3, 0);

    // Random traffic against the model.
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      begintransfer = 1'($urandom_range(0, 1));
      read          = 1'($urandom_range(0, 1));
      write         = 1'($urandom_range(0, 1));
      address       = 5'($urandom_range(0, 31));
      writedata     = $urandom;
      if ($urandom_range(0, 3) != 0) writedata[0] = 1'b0;
      evt_in        = 6'($urandom);
      want = model_read(int'(address));
      model_step();
      cyc();
      chk("rand", readdata, want);
    end
    begintransfer = 0; read = 0; write = 0; evt_in = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
